alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational `alu` between two requesters, e.g. the EX-stage integer path (port 0) and the address/CSR helper path (port 1). It accepts operation requests over valid/ready handshakes and picks one per cycle with round-robin priority. The selected operation is registered into an issue slot that drives the ALU inputs, and the ALU result is captured into a per-port response buffer. It sits between the requesters and the `alu` instance and owns every ALU input.

---
 rtl/alu_share_arb.sv | 190 +++++++++++++++++++
 tb/tb_alu_share_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Purpose : shares one combinational ALU between two requesters using round-robin arbitration.
// Latency : request handshake in cycle N, ALU driven in N+1, response valid in N+2.
// Backpres: a full, undrained response buffer stalls the issue slot and blocks both request ports.
//
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   req{0,1}_valid/_ready  - request handshake; op/src1/src2/tag carry the operation
//   rsp{0,1}_valid/_ready  - per-port response buffer handshake; result/tag/err carry the response
//   alu_op/src1/src2       - ALU inputs, driven from the issue-slot registers
//   alu_result             - combinational ALU result
module alu_share_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [11:0]      req0_op,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [11:0]      req1_op,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err,
  output logic [11:0]      alu_op,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result
);

  // Issue slot
  logic             s1_valid_q, s1_valid_d;
  logic             s1_port_q,  s1_port_d;
  logic [11:0]      s1_op_q,    s1_op_d;
  logic [31:0]      s1_src1_q,  s1_src1_d;
  logic [31:0]      s1_src2_q,  s1_src2_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s1_err_q,   s1_err_d;
  logic             last_grant_q, last_grant_d;

  // Response buffers
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
  logic [TAG_W-1:0] rsp0_tag_q, rsp0_tag_d, rsp1_tag_q, rsp1_tag_d;
  logic             rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;

  logic [1:0]       load;
  logic             complete, can_accept, grant0, grant1, accept;
  logic [11:0]      sel_op;
  logic [31:0]      sel_src1, sel_src2, rsp_data;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_err;

  // A buffer can take the slot's result when empty or being drained this cycle.
  assign load[0]    = s1_valid_q & ~s1_port_q & (~rsp_valid_q[0] | rsp0_ready);
  assign load[1]    = s1_valid_q &  s1_port_q & (~rsp_valid_q[1] | rsp1_ready);
  assign complete   = |load;
  assign can_accept = ~s1_valid_q | complete;

  // Round robin: under contention the port that did not win last time is granted.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  assign grant0 = req0_valid & ~grant1;

  // Gated by reset so no handshake can be seen while state is being cleared.
  assign req0_ready = ~reset & can_accept & grant0;
  assign req1_ready = ~reset & can_accept & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_op   = grant1 ? req1_op   : req0_op;
  assign sel_src1 = grant1 ? req1_src1 : req0_src1;
  assign sel_src2 = grant1 ? req1_src2 : req0_src2;
  assign sel_tag  = grant1 ? req1_tag  : req0_tag;
  // Exactly one bit set is legal; x & (x-1) clears the lowest set bit.
  assign sel_err  = ~((sel_op != 12'd0) && ((sel_op & (sel_op - 12'd1)) == 12'd0));

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_port_d    = s1_port_q;
    s1_op_d      = s1_op_q;
    s1_src1_d    = s1_src1_q;
    s1_src2_d    = s1_src2_q;
    s1_tag_d     = s1_tag_q;
    s1_err_d     = s1_err_q;
    last_grant_d = last_grant_q;
    if (complete) begin
      s1_valid_d = 1'b0;
    end
    // Completion and acceptance in the same cycle reload the slot with no bubble.
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_port_d    = grant1;
      s1_op_d      = sel_err ? 12'd0 : sel_op;
      s1_src1_d    = sel_src1;
      s1_src2_d    = sel_src2;
      s1_tag_d     = sel_tag;
      s1_err_d     = sel_err;
      last_grant_d = grant1;
    end
  end

  assign rsp_data = s1_err_q ? 32'd0 : alu_result;

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_tag_d    = rsp0_tag_q;
    rsp0_err_d    = rsp0_err_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_tag_d    = rsp1_tag_q;
    rsp1_err_d    = rsp1_err_q;
    if (load[0]) begin
      rsp_valid_d[0] = 1'b1;
      rsp0_result_d  = rsp_data;
      rsp0_tag_d     = s1_tag_q;
      rsp0_err_d     = s1_err_q;
    end else if (rsp0_ready) begin
      rsp_valid_d[0] = 1'b0;
    end
    if (load[1]) begin
      rsp_valid_d[1] = 1'b1;
      rsp1_result_d  = rsp_data;
      rsp1_tag_d     = s1_tag_q;
      rsp1_err_d     = s1_err_q;
    end else if (rsp1_ready) begin
      rsp_valid_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_port_q     <= 1'b0;
      s1_op_q       <= 12'd0;
      s1_src1_q     <= 32'd0;
      s1_src2_q     <= 32'd0;
      s1_tag_q      <= '0;
      s1_err_q      <= 1'b0;
      last_grant_q  <= 1'b1;  // port 0 wins the first contention
      rsp_valid_q   <= 2'b00;
      rsp0_result_q <= 32'd0;
      rsp0_tag_q    <= '0;
      rsp0_err_q    <= 1'b0;
      rsp1_result_q <= 32'd0;
      rsp1_tag_q    <= '0;
      rsp1_err_q    <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_port_q     <= s1_port_d;
      s1_op_q       <= s1_op_d;
      s1_src1_q     <= s1_src1_d;
      s1_src2_q     <= s1_src2_d;
      s1_tag_q      <= s1_tag_d;
      s1_err_q      <= s1_err_d;
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_tag_q    <= rsp0_tag_d;
      rsp0_err_q    <= rsp0_err_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_tag_q    <= rsp1_tag_d;
      rsp1_err_q    <= rsp1_err_d;
    end
  end

  assign alu_op      = s1_valid_q ? s1_op_q : 12'd0;
  assign alu_src1    = s1_src1_q;
  assign alu_src2    = s1_src2_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp0_result_q;
  assign rsp0_tag    = rsp0_tag_q;
  assign rsp0_err    = rsp0_err_q;
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp1_result_q;
  assign rsp1_tag    = rsp1_tag_q;
  assign rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed scenarios plus a randomized scoreboard run.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  q_vld = 2'b00;
  logic [11:0] q_op [2];
  logic [31:0] q_a [2];
  logic [31:0] q_b [2];
  logic [3:0]  q_tag [2];
  logic [1:0]  r_rdy = 2'b11;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result, alu_src1, alu_src2, alu_result;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic [11:0] alu_op;

  logic [1:0]  rdy, rv, re;
  logic [31:0] rr [2];
  logic [3:0]  rt [2];
  assign rdy   = {req1_ready, req0_ready};
  assign rv    = {rsp1_valid, rsp0_valid};
  assign re    = {rsp1_err, rsp0_err};
  assign rr[0] = rsp0_result;
  assign rr[1] = rsp1_result;
  assign rt[0] = rsp0_tag;
  assign rt[1] = rsp1_tag;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  alu_share_arb #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(q_vld[0]), .req0_ready(req0_ready), .req0_op(q_op[0]),
    .req0_src1(q_a[0]), .req0_src2(q_b[0]), .req0_tag(q_tag[0]),
    .req1_valid(q_vld[1]), .req1_ready(req1_ready), .req1_op(q_op[1]),
    .req1_src1(q_a[1]), .req1_src2(q_b[1]), .req1_tag(q_tag[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(r_rdy[0]), .rsp0_result(rsp0_result),
    .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(r_rdy[1]), .rsp1_result(rsp1_result),
    .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result)
  );

  // Behavioural stand-in for the shared ALU; unknown op codes give a poison value.
  function automatic logic [31:0] alu_fn(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return a << b[4:0];
      12'h008: return {31'd0, $signed(a) < $signed(b)};
      12'h010: return {31'd0, a < b};
      12'h020: return a ^ b;
      12'h040: return a >> b[4:0];
      12'h080: return 32'($signed(a) >>> b[4:0]);
      12'h100: return a | b;
      12'h200: return a & b;
      12'h400: return a + {b[19:0], 12'd0};
      12'h800: return {b[19:0], 12'd0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_src1, alu_src2);

  function automatic logic [11:0] rand_legal();
    logic [11:0] o;
    o = 12'h001 << $urandom_range(0, 11);
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
    q_vld[p] = 1'b1;
    q_op[p]  = op;
    q_a[p]   = a;
    q_b[p]   = b;
    q_tag[p] = t;
  endtask

  task automatic idle(input int n);
    q_vld = 2'b00;
    r_rdy = 2'b11;
    repeat (n) step();
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      q_op[p] = 12'h001; q_a[p] = 32'd0; q_b[p] = 32'd0; q_tag[p] = 4'd0;
    end
    #2 reset = 1'b1;
    q_vld = 2'b11;
    @(negedge clk);
    n_cmp++; if (rv !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rv); end
    n_cmp++; if (alu_op !== 12'd0) begin n_fail++; $display("FAIL rst_alu_op: got %h want 0", alu_op); end
    n_cmp++; if ({alu_src1, alu_src2} !== 64'd0) begin n_fail++; $display("FAIL rst_alu_src: got %h %h want 0", alu_src1, alu_src2); end
    n_cmp++; if ({rr[0], rr[1], rt[0], rt[1], re} !== 74'd0) begin n_fail++; $display("FAIL rst_rsp_data: got %h %h %h %h %b want 0", rr[0], rr[1], rt[0], rt[1], re); end
    n_cmp++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", rdy); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Starts in the first cycle after reset release: port 0 must win first.
  task automatic test_contention();
    logic [31:0] er [8];
    logic [3:0]  et [8];
    r_rdy = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        for (int p = 0; p < 2; p++)
          set_req(p, rand_legal(), $urandom(), $urandom(), 4'(c * 2 + p));
        er[c] = alu_fn(q_op[c % 2], q_a[c % 2], q_b[c % 2]);
        et[c] = q_tag[c % 2];
      end else begin
        q_vld = 2'b00;
      end
      @(negedge clk);
      if (c < 6) begin
        n_cmp++; if (rdy !== (c % 2 == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_grant c%0d: got %b want port %0d", c, rdy, c % 2); end
      end
      if (c >= 2) begin
        n_cmp++; if (rv !== (c % 2 == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_rsp_valid c%0d: got %b", c, rv); end
        n_cmp++; if (rr[c % 2] !== er[c - 2] || rt[c % 2] !== et[c - 2]) begin n_fail++; $display("FAIL cont_rsp_data c%0d: got %h/%h want %h/%h", c, rr[c % 2], rt[c % 2], er[c - 2], et[c - 2]); end
      end
      step();
    end
  endtask

  task automatic test_single_add();
    r_rdy = 2'b11;
    set_req(0, 12'h001, 32'd3, 32'd5, 4'd2);
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b want 01", rdy); end
    step();
    q_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (alu_op !== 12'h001 || alu_src1 !== 32'd3 || alu_src2 !== 32'd5) begin n_fail++; $display("FAIL add_alu_in: got %h %0d %0d want 001 3 5", alu_op, alu_src1, alu_src2); end
    n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL add_early_rsp: got %b want 0", rv[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (rv[0] !== 1'b1 || rr[0] !== 32'd8 || rt[0] !== 4'd2 || re[0] !== 1'b0) begin n_fail++; $display("FAIL add_rsp: got v%b r%0d t%0d e%b want v1 r8 t2 e0", rv[0], rr[0], rt[0], re[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %b want 0", rv[0]); end
    idle(1);
  endtask

  task automatic test_backpressure();
    r_rdy = 2'b01;
    set_req(1, 12'h002, 32'd10, 32'd4, 4'd6);
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL bp_acc_a: got %b want 10", rdy); end
    step();
    set_req(1, 12'h001, 32'd1, 32'd2, 4'd7);
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL bp_acc_b: got %b want 10", rdy); end
    step();
    q_vld[1] = 1'b0;
    set_req(0, 12'h020, 32'h0F0, 32'h00F, 4'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready c%0d: got %b want 00", c, rdy); end
      n_cmp++; if (alu_op !== 12'h001 || alu_src1 !== 32'd1 || alu_src2 !== 32'd2) begin n_fail++; $display("FAIL bp_alu_hold c%0d: got %h %0d %0d want 001 1 2", c, alu_op, alu_src1, alu_src2); end
      n_cmp++; if (rv[1] !== 1'b1 || rr[1] !== 32'd6) begin n_fail++; $display("FAIL bp_rsp1_hold c%0d: got v%b r%0d want v1 r6", c, rv[1], rr[1]); end
      step();
    end
    r_rdy = 2'b11;
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL bp_release_ready: got %b want 01", rdy); end
    step();
    q_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (rv[1] !== 1'b1 || rr[1] !== 32'd3 || rt[1] !== 4'd7) begin n_fail++; $display("FAIL bp_rsp1_b: got v%b r%0d t%0d want v1 r3 t7", rv[1], rr[1], rt[1]); end
    n_cmp++; if (alu_op !== 12'h020 || alu_src1 !== 32'h0F0) begin n_fail++; $display("FAIL bp_alu_c: got %h %h want 020 f0", alu_op, alu_src1); end
    step();
    @(negedge clk);
    n_cmp++; if (rv !== 2'b01 || rr[0] !== 32'h0FF || rt[0] !== 4'd5) begin n_fail++; $display("FAIL bp_rsp0_c: got v%b r%h t%0d want v01 rff t5", rv, rr[0], rt[0]); end
    idle(1);
  endtask

  task automatic test_illegal_op();
    r_rdy = 2'b11;
    set_req(1, 12'h003, 32'd7, 32'd9, 4'd3);
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL ill_ready: got %b want 10", rdy); end
    step();
    q_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (alu_op !== 12'd0) begin n_fail++; $display("FAIL ill_alu_op: got %h want 000", alu_op); end
    step();
    @(negedge clk);
    n_cmp++; if (rv[1] !== 1'b1 || re[1] !== 1'b1 || rr[1] !== 32'd0 || rt[1] !== 4'd3) begin n_fail++; $display("FAIL ill_rsp: got v%b e%b r%h t%0d want v1 e1 r0 t3", rv[1], re[1], rr[1], rt[1]); end
    idle(1);
  endtask

  task automatic test_drain_fill();
    logic [31:0] er [4];
    r_rdy = 2'b11;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        set_req(0, rand_legal(), $urandom(), $urandom(), 4'(c + 8));
        er[c] = alu_fn(q_op[0], q_a[0], q_b[0]);
      end else begin
        q_vld = 2'b00;
      end
      @(negedge clk);
      if (c < 4) begin
        n_cmp++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL df_ready c%0d: got %b want 1", c, rdy[0]); end
      end
      if (c >= 2 && c < 6) begin
        n_cmp++; if (rv[0] !== 1'b1 || rr[0] !== er[c - 2] || rt[0] !== 4'(c + 6)) begin n_fail++; $display("FAIL df_rsp c%0d: got v%b r%h t%0d want v1 r%h t%0d", c, rv[0], rr[0], rt[0], er[c - 2], c + 6); end
      end
      if (c == 6) begin
        n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL df_end: got %b want 0", rv[0]); end
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [1:0] acc;
    int   last_acc;
    logic known;
    exp_t e;
    known = 1'b0;
    last_acc = 0;
    q_vld = 2'b00;
    for (int c = 0; c < 460; c++) begin
      if (c < 400) begin
        for (int p = 0; p < 2; p++)
          if (!q_vld[p] && $urandom_range(0, 2) != 0)
            set_req(p, ($urandom_range(0, 7) == 0) ? 12'($urandom()) : rand_legal(),
                    $urandom(), $urandom(), 4'($urandom()));
        r_rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      end else begin
        r_rdy = 2'b11;
      end
      @(negedge clk);
      acc = q_vld & rdy;
      n_cmp++; if (rdy === 2'b11) begin n_fail++; $display("FAIL rnd_dual_ready c%0d", c); end
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          if (q_vld == 2'b11 && known) begin
            n_cmp++; if (p == last_acc) begin n_fail++; $display("FAIL rnd_rr c%0d: got port %0d want port %0d", c, p, 1 - p); end
          end
          known = 1'b1;
          last_acc = p;
          e.err = ($countones(q_op[p]) != 1);
          e.res = e.err ? 32'd0 : alu_fn(q_op[p], q_a[p], q_b[p]);
          e.tag = q_tag[p];
          if (p == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        if (rv[p] === 1'b1 && r_rdy[p]) begin
          n_cmp++;
          if ((p == 0 ? sb0.size() : sb1.size()) == 0) begin
            n_fail++; $display("FAIL rnd_unexpected_rsp p%0d c%0d: got r%h", p, c, rr[p]);
          end else begin
            e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
            if ({rr[p], rt[p], re[p]} !== {e.res, e.tag, e.err}) begin
              n_fail++; $display("FAIL rnd_rsp p%0d c%0d: got %h/%0d/%b want %h/%0d/%b", p, c, rr[p], rt[p], re[p], e.res, e.tag, e.err);
            end
          end
        end
      end
      step();
      q_vld = q_vld & ~acc;
      if (c >= 399) q_vld = 2'b00;
    end
    n_cmp++; if (sb0.size() != 0 || sb1.size() != 0 || rv !== 2'b00) begin n_fail++; $display("FAIL rnd_leftover: got %0d/%0d pending, valid %b, want none", sb0.size(), sb1.size(), rv); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] e0, e1;
    r_rdy = 2'b10;
    set_req(0, 12'h001, 32'd1, 32'd1, 4'd1);
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL mid_acc_a: got %b want 01", rdy); end
    step();
    set_req(0, 12'h001, 32'd2, 32'd2, 4'd2);
    step();
    q_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (rv[0] !== 1'b1 || alu_op !== 12'h001) begin n_fail++; $display("FAIL mid_pre: got v%b op%h want v1 op001", rv[0], alu_op); end
    #1 reset = 1'b1;
    q_vld = 2'b11;
    #1;
    n_cmp++; if (rv !== 2'b00 || alu_op !== 12'd0 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0) begin n_fail++; $display("FAIL mid_async: got v%b op%h s%h %h want all 0", rv, alu_op, alu_src1, alu_src2); end
    n_cmp++; if (rr[0] !== 32'd0 || rt[0] !== 4'd0 || rdy !== 2'b00) begin n_fail++; $display("FAIL mid_async_data: got r%h t%0d rdy%b want 0", rr[0], rt[0], rdy); end
    @(posedge clk);
    #1 reset = 1'b0;
    r_rdy = 2'b11;
    set_req(0, 12'h100, 32'h50, 32'h05, 4'd9);
    set_req(1, 12'h002, 32'd20, 32'd5, 4'd4);
    e0 = 32'h55;
    e1 = 32'd15;
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant: got %b want 01", rdy); end
    step();
    q_vld[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL mid_second_grant: got %b want 10", rdy); end
    step();
    q_vld = 2'b00;
    @(negedge clk);
    n_cmp++; if (rv !== 2'b01 || rr[0] !== e0 || rt[0] !== 4'd9) begin n_fail++; $display("FAIL mid_rsp0: got v%b r%h t%0d want v01 r%h t9", rv, rr[0], rt[0], e0); end
    step();
    @(negedge clk);
    n_cmp++; if (rv !== 2'b10 || rr[1] !== e1 || rt[1] !== 4'd4) begin n_fail++; $display("FAIL mid_rsp1: got v%b r%0d t%0d want v10 r%0d t4", rv, rr[1], rt[1], e1); end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    idle(1);
    test_single_add();
    test_backpressure();
    test_illegal_op();
    test_drain_fill();
    idle(1);
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
